// File: rtl/gs_audio_out.sv
// gs_audio_out: box-averages the 15-bit GS OUTL/OUTR mix into 16-bit signed PCM with volume shift,
// and drives one first-order sigma-delta pin DAC per channel. Define GS_DCBLOCK_EN for the stage-2 DC blocker.
module gs_audio_out #(
  parameter int SMP_LOG2 = 11,
  parameter int DC_SHIFT = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [14:0] inL_i,
  input  logic [14:0] inR_i,
  input  logic [2:0]  vol_i,
  output logic [15:0] pcmL_o,
  output logic [15:0] pcmR_o,
  output logic        pcmValid_o,
  output logic        dacL_o,
  output logic        dacR_o
);

  localparam int ACC_W = 15 + SMP_LOG2;

  if (DC_SHIFT < 1 || DC_SHIFT > 16) begin : gBadDcShift
    $error("gs_audio_out: DC_SHIFT must be in 1..16");
  end

  // Stage 0: window counter and per-channel accumulators
  logic [SMP_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    accL_q, accL_d, accR_q, accR_d;
  logic [ACC_W-1:0]    sumL, sumR;
  logic                windowEnd;
  logic [14:0]         avgL_q, avgL_d, avgR_q, avgR_d;
  logic                avgValid_q, avgValid_d;

  // Stage 1..3 pipeline
  logic signed [15:0]  sL_q, sL_d, sR_q, sR_d;
  logic                sValid_q, sValid_d;
  logic signed [15:0]  yL_q, yL_d, yR_q, yR_d;
  logic                yValid_q, yValid_d;
  logic [2:0]          vol_q, vol_d;
  logic signed [15:0]  shL, shR;
  logic signed [15:0]  pcmL_q, pcmL_d, pcmR_q, pcmR_d;
  logic                pcmValid_q, pcmValid_d;

  // Sigma-delta modulators
  logic [15:0]         sdL_q, sdL_d, sdR_q, sdR_d;
  logic                dacL_q, dacL_d, dacR_q, dacR_d;
  logic                carryL, carryR;

`ifdef GS_DCBLOCK_EN
  logic signed [15:0]  sPrevL_q, sPrevL_d, sPrevR_q, sPrevR_d;

  // y = s - s_prev + y_prev - (y_prev >>> DC_SHIFT); y_prev is the stage-2 register itself
  function automatic logic signed [15:0] dcStep(input logic signed [15:0] s,
                                                input logic signed [15:0] sp,
                                                input logic signed [15:0] yp);
    logic signed [17:0] s18, sp18, yp18, t;
    s18  = {{2{s[15]}}, s};
    sp18 = {{2{sp[15]}}, sp};
    yp18 = {{2{yp[15]}}, yp};
    t    = s18 - sp18 + yp18 - (yp18 >>> DC_SHIFT);
    if (t > 18'sd32767)
      return 16'sh7FFF;
    else if (t < -18'sd32768)
      return 16'sh8000;
    else
      return t[15:0];
  endfunction
`endif

  // Offset-binary average to signed PCM: midpoint 0x4000 maps to zero, full scale doubled
  function automatic logic signed [15:0] toSigned(input logic [14:0] avg);
    logic [15:0] centred;
    centred = {1'b0, avg} - 16'h4000;
    return {centred[14:0], 1'b0};
  endfunction

  always_comb begin
    windowEnd  = &cnt_q;
    cnt_d      = cnt_q + SMP_LOG2'(1);
    sumL       = accL_q + ACC_W'(inL_i);
    sumR       = accR_q + ACC_W'(inR_i);
    accL_d     = windowEnd ? '0 : sumL;
    accR_d     = windowEnd ? '0 : sumR;
    avgL_d     = windowEnd ? sumL[ACC_W-1:SMP_LOG2] : avgL_q;
    avgR_d     = windowEnd ? sumR[ACC_W-1:SMP_LOG2] : avgR_q;
    avgValid_d = windowEnd;
  end

  always_comb begin
    sValid_d = avgValid_q;
    sL_d     = avgValid_q ? toSigned(avgL_q) : sL_q;
    sR_d     = avgValid_q ? toSigned(avgR_q) : sR_q;

    yValid_d = sValid_q;
    vol_d    = sValid_q ? vol_i : vol_q;
`ifdef GS_DCBLOCK_EN
    sPrevL_d = sValid_q ? sL_q : sPrevL_q;
    sPrevR_d = sValid_q ? sR_q : sPrevR_q;
    yL_d     = sValid_q ? dcStep(sL_q, sPrevL_q, yL_q) : yL_q;
    yR_d     = sValid_q ? dcStep(sR_q, sPrevR_q, yR_q) : yR_q;
`else
    yL_d     = sValid_q ? sL_q : yL_q;
    yR_d     = sValid_q ? sR_q : yR_q;
`endif

    shL        = yL_q >>> vol_q;
    shR        = yR_q >>> vol_q;
    pcmValid_d = yValid_q;
    pcmL_d     = yValid_q ? shL : pcmL_q;
    pcmR_d     = yValid_q ? shR : pcmR_q;
  end

  // Carry out of the offset-binary accumulation is the 1-bit DAC output
  always_comb begin
    {carryL, sdL_d} = {1'b0, sdL_q} + {1'b0, pcmL_q ^ 16'h8000};
    {carryR, sdR_d} = {1'b0, sdR_q} + {1'b0, pcmR_q ^ 16'h8000};
    dacL_d = carryL;
    dacR_d = carryR;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      accL_q     <= '0;
      accR_q     <= '0;
      avgL_q     <= '0;
      avgR_q     <= '0;
      avgValid_q <= 1'b0;
      sL_q       <= '0;
      sR_q       <= '0;
      sValid_q   <= 1'b0;
      yL_q       <= '0;
      yR_q       <= '0;
      yValid_q   <= 1'b0;
      vol_q      <= '0;
      pcmL_q     <= '0;
      pcmR_q     <= '0;
      pcmValid_q <= 1'b0;
      sdL_q      <= '0;
      sdR_q      <= '0;
      dacL_q     <= 1'b0;
      dacR_q     <= 1'b0;
`ifdef GS_DCBLOCK_EN
      sPrevL_q   <= '0;
      sPrevR_q   <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      accL_q     <= accL_d;
      accR_q     <= accR_d;
      avgL_q     <= avgL_d;
      avgR_q     <= avgR_d;
      avgValid_q <= avgValid_d;
      sL_q       <= sL_d;
      sR_q       <= sR_d;
      sValid_q   <= sValid_d;
      yL_q       <= yL_d;
      yR_q       <= yR_d;
      yValid_q   <= yValid_d;
      vol_q      <= vol_d;
      pcmL_q     <= pcmL_d;
      pcmR_q     <= pcmR_d;
      pcmValid_q <= pcmValid_d;
      sdL_q      <= sdL_d;
      sdR_q      <= sdR_d;
      dacL_q     <= dacL_d;
      dacR_q     <= dacR_d;
`ifdef GS_DCBLOCK_EN
      sPrevL_q   <= sPrevL_d;
      sPrevR_q   <= sPrevR_d;
`endif
    end
  end

  assign pcmL_o     = pcmL_q;
  assign pcmR_o     = pcmR_q;
  assign pcmValid_o = pcmValid_q;
  assign dacL_o     = dacL_q;
  assign dacR_o     = dacR_q;

endmodule

// File: tb/tb_gs_audio_out.sv
// tb_gs_audio_out: table vectors, hand-written corner sequences and randomized stimulus for gs_audio_out,
// all checked against a window-level reference model (SMP_LOG2=4, DC_SHIFT=2).
module tb_gs_audio_out;

  localparam int L   = 4;
  localparam int N   = 1 << L;
  localparam int DCS = 2;
  localparam int NV  = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] inL   = 15'h4000;
  logic [14:0] inR   = 15'h4000;
  logic [2:0]  vol   = 3'd0;
  logic [15:0] pcmL, pcmR;
  logic        pcmValid, dacL, dacR;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [14:0] inL;
    logic [14:0] inR;
    logic [2:0]  vol;
    logic [15:0] expL;
    logic [15:0] expR;
  } vec_t;
  vec_t vecs[NV];

  gs_audio_out #(.SMP_LOG2(L), .DC_SHIFT(DCS)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .inL_i     (inL),
    .inR_i     (inR),
    .vol_i     (vol),
    .pcmL_o    (pcmL),
    .pcmR_o    (pcmR),
    .pcmValid_o(pcmValid),
    .dacL_o    (dacL),
    .dacR_o    (dacR)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [14:0] l, input logic [14:0] r, input logic [2:0] v);
    inL = l;
    inR = r;
    vol = v;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at the falling edge of the next strobe cycle
  task automatic waitStrobe(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 4 * N; c++) begin
      @(negedge clk);
      if (pcmValid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      stepCycle();
    end
    if (!seen) checkOutput("strobe_timeout", 0, 1);
  endtask

  function automatic int centred(input int avg);
    return (avg - 16384) * 2;
  endfunction

  function automatic int dcModel(input int s, input int sp, input int yp);
    int y;
    y = s - sp + yp - (yp >>> DCS);
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  // Reference model: window sums, sample conversion at T+2, publication at T+4, SD as a carry count
  int          cyc, pendT, winL, winR, pendAvgL, pendAvgR, pendPcmL, pendPcmR, sl, sr;
  int          sPrevL, sPrevR, yPrevL, yPrevR;
  bit          pending, armed;
  logic [15:0] expL, expR;
  logic        expV;
  longint      uSumL, uSumR, onesL, onesR;

  always @(negedge clk) begin
    if (reset) begin
      armed   = 1'b1;
      cyc     = 0;
      winL    = 0;
      winR    = 0;
      pending = 1'b0;
      expL    = '0;
      expR    = '0;
      uSumL   = 0;
      uSumR   = 0;
      onesL   = 0;
      onesR   = 0;
      sPrevL  = 0;
      sPrevR  = 0;
      yPrevL  = 0;
      yPrevR  = 0;
    end else if (armed) begin
      expV = 1'b0;
      if (pending && cyc == pendT + 2) begin
        sl = centred(pendAvgL);
        sr = centred(pendAvgR);
`ifdef GS_DCBLOCK_EN
        yPrevL = dcModel(sl, sPrevL, yPrevL);
        yPrevR = dcModel(sr, sPrevR, yPrevR);
        sPrevL = sl;
        sPrevR = sr;
        sl     = yPrevL;
        sr     = yPrevR;
`endif
        pendPcmL = sl >>> vol;
        pendPcmR = sr >>> vol;
      end
      if (pending && cyc == pendT + 4) begin
        expL    = 16'(pendPcmL);
        expR    = 16'(pendPcmR);
        expV    = 1'b1;
        pending = 1'b0;
      end
      checkOutput("model_valid", pcmValid, expV);
      checkOutput("model_pcmL", pcmL, expL);
      checkOutput("model_pcmR", pcmR, expR);
      onesL += dacL;
      onesR += dacR;
      checkOutput("model_dacL_ones", onesL, uSumL >> 16);
      checkOutput("model_dacR_ones", onesR, uSumR >> 16);
      uSumL += expL ^ 16'h8000;
      uSumR += expR ^ 16'h8000;
      winL += inL;
      winR += inR;
      if (cyc % N == N - 1) begin
        pendAvgL = winL >> L;
        pendAvgR = winR >> L;
        winL     = 0;
        winR     = 0;
        pending  = 1'b1;
        pendT    = cyc;
      end
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    int firstV, secondV, strobes;

    vecs[0] = '{15'h4000, 15'h4000, 3'd0, 16'h0000, 16'h0000};
    vecs[1] = '{15'h7FFF, 15'h0000, 3'd0, 16'h7FFE, 16'h8000};
    vecs[2] = '{15'h7FFF, 15'h0000, 3'd1, 16'h3FFF, 16'hC000};
    vecs[3] = '{15'h7FFF, 15'h0000, 3'd3, 16'h0FFF, 16'hF000};
    vecs[4] = '{15'h6000, 15'h2000, 3'd0, 16'h4000, 16'hC000};
    vecs[5] = '{15'h4001, 15'h3FFF, 3'd0, 16'h0002, 16'hFFFE};
    vecs[6] = '{15'h5000, 15'h3000, 3'd2, 16'h0800, 16'hF800};
    vecs[7] = '{15'h0000, 15'h7FFF, 3'd7, 16'hFF00, 16'h00FF};

    // Reset for 3 clocks at midscale: strobe timing and DAC toggling
    applyStimulus(15'h4000, 15'h4000, 3'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    firstV  = -1;
    secondV = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("reset_pcmL", pcmL, 0);
        checkOutput("reset_pcmR", pcmR, 0);
        checkOutput("reset_valid", pcmValid, 0);
        checkOutput("reset_dacL", dacL, 0);
      end
      if (pcmValid === 1'b1) begin
        if (firstV < 0) firstV = c;
        else if (secondV < 0) secondV = c;
      end
      if (c >= 1 && c <= 10) checkOutput("dacL_toggle", dacL, (c % 2 == 0) ? 1 : 0);
      stepCycle();
    end
    checkOutput("first_strobe_cycle", firstV, N + 3);
    checkOutput("strobe_period", secondV - firstV, N);

`ifndef GS_DCBLOCK_EN
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].inL, vecs[i].inR, vecs[i].vol);
      waitStrobe(seen);
      stepCycle();
      waitStrobe(seen);
      checkOutput($sformatf("vec%0d_pcmL", i), pcmL, vecs[i].expL);
      checkOutput($sformatf("vec%0d_pcmR", i), pcmR, vecs[i].expR);
      stepCycle();
    end

    // VOL 1 -> 3 in the middle of a window: PCM holds until the next strobe
    applyStimulus(15'h7FFF, 15'h0000, 3'd1);
    waitStrobe(seen);
    stepCycle();
    waitStrobe(seen);
    checkOutput("vol1_pcmL", pcmL, 16'h3FFF);
    stepCycle();
    repeat (5) stepCycle();
    vol  = 3'd3;
    seen = 1'b0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      if (pcmValid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      checkOutput("vol_hold_pcmL", pcmL, 16'h3FFF);
      stepCycle();
    end
    checkOutput("vol_change_strobe_seen", seen, 1);
    checkOutput("vol3_pcmL", pcmL, 16'h0FFF);
    checkOutput("vol3_pcmR", pcmR, 16'hF000);
    stepCycle();

    // Left input alternating 0x4000/0x4800 every clock averages to 0x4400
    applyStimulus(15'h4000, 15'h4000, 3'd0);
    strobes = 0;
    for (int c = 0; c < 6 * N && strobes < 3; c++) begin
      inL = c[0] ? 15'h4800 : 15'h4000;
      @(negedge clk);
      if (pcmValid === 1'b1) begin
        strobes++;
        if (strobes == 3) checkOutput("alternating_pcmL", pcmL, 16'h0800);
      end
      stepCycle();
    end
    checkOutput("alternating_strobes", strobes, 3);
`endif

    // Reset for one clock at cnt=9 discards the window and restarts timing
    applyStimulus(15'h6000, 15'h2000, 3'd0);
    waitStrobe(seen);
    stepCycle();
    waitStrobe(seen);
    stepCycle();
    repeat (5) stepCycle();
    reset = 1'b1;
    stepCycle();
    reset  = 1'b0;
    firstV = -1;
    for (int c = 0; c < 2 * N + 8 && firstV < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("midreset_pcmL", pcmL, 0);
        checkOutput("midreset_valid", pcmValid, 0);
      end
      if (pcmValid === 1'b1) firstV = c;
      stepCycle();
    end
    checkOutput("midreset_first_strobe", firstV, N + 3);

`ifdef GS_DCBLOCK_EN
    // Step response and saturation of the DC blocker (DC_SHIFT=2)
    applyStimulus(15'h4000, 15'h4000, 3'd0);
    repeat (40) begin
      waitStrobe(seen);
      stepCycle();
    end
    waitStrobe(seen);
    repeat (13) stepCycle();
    applyStimulus(15'h6000, 15'h4000, 3'd0);
    waitStrobe(seen);
    stepCycle();
    waitStrobe(seen);
    checkOutput("dc_step_pcmL", pcmL, 16'h4000);
    stepCycle();
    waitStrobe(seen);
    checkOutput("dc_decay1_pcmL", pcmL, 16'h3000);
    stepCycle();
    waitStrobe(seen);
    checkOutput("dc_decay2_pcmL", pcmL, 16'h2400);
    stepCycle();
    applyStimulus(15'h0000, 15'h4000, 3'd0);
    repeat (50) begin
      waitStrobe(seen);
      stepCycle();
    end
    waitStrobe(seen);
    repeat (13) stepCycle();
    applyStimulus(15'h7FFF, 15'h4000, 3'd0);
    waitStrobe(seen);
    stepCycle();
    waitStrobe(seen);
    checkOutput("dc_saturate_pcmL", pcmL, 16'h7FFF);
    stepCycle();
`endif

    // Randomized inputs, volume changes and occasional resets against the model
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 7))
        0:       applyStimulus(15'h7FFF, 15'h0000, vol);
        1:       applyStimulus(15'h0000, 15'h7FFF, vol);
        default: applyStimulus(15'($urandom_range(0, 32767)), 15'($urandom_range(0, 32767)), vol);
      endcase
      if ($urandom_range(0, 40) == 0) vol = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
      end
      stepCycle();
    end
    repeat (2 * N) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
